// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : Buffered UART transmitter. A TX FIFO feeds a frame serialiser
//            with runtime-selectable data width (5..MAX_DATA_WIDTH), optional
//            even/odd parity, one or two stop bits, CTS flow control and
//            break generation. Single clock domain (uart_clk).
// Ports    : uart_clk, rst           - clock, synchronous active-high reset
//            baud_tick               - one-cycle pulse, OVERSAMPLE_RATE x baud
//            wr_data, wr_en          - FIFO enqueue
//            cfg_*                   - frame format, latched per frame
//            tx_enable, cts_n        - start gating, sampled at frame start
//            send_break, ovf_clr     - break level request, overflow clear
//            tx_serial               - serial line, idle high
//            tx_empty/full/level     - FIFO status
//            tx_active, tx_done      - serialiser busy, end-of-frame pulse
//            tx_overflow             - sticky dropped-write flag
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_DATA_WIDTH  = 8,
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic                          uart_clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [MAX_DATA_WIDTH-1:0]     wr_data,
    input  logic                          wr_en,
    input  logic [3:0]                    cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic                          tx_enable,
    input  logic                          cts_n,
    input  logic                          send_break,
    input  logic                          ovf_clr,
    output logic                          tx_serial,
    output logic                          tx_empty,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic                          tx_overflow
);

    localparam int              c_AW        = $clog2(FIFO_DEPTH);
    localparam int              c_LW        = c_AW + 1;
    localparam int              c_TW        = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE_RATE - 1);
    localparam logic [3:0]      c_MAXW      = 4'(MAX_DATA_WIDTH);
    localparam logic [3:0]      c_MINW      = 4'd5;
    localparam logic [c_LW-1:0] c_DEPTH     = c_LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and status
    // ------------------------------------------------------------------
    logic [MAX_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]           r_wr_ptr;
    logic [c_AW-1:0]           r_rd_ptr;
    logic [c_LW-1:0]           r_count;
    logic [c_LW-1:0]           w_count_nxt;
    logic                      r_empty;
    logic                      r_full;
    logic                      r_overflow;
    logic                      w_wr_acc;
    logic                      w_pop;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_TW-1:0]           r_tick;
    logic [c_TW-1:0]           w_tick_nxt;
    logic [c_TW-1:0]           w_tick_run;
    logic [3:0]                r_bit;
    logic [3:0]                w_bit_nxt;
    logic [MAX_DATA_WIDTH-1:0] r_shift;
    logic [MAX_DATA_WIDTH-1:0] w_shift_nxt;
    logic [3:0]                r_nbits;
    logic [3:0]                w_nbits_nxt;
    logic                      r_par_en;
    logic                      w_par_en_nxt;
    logic                      r_stop2;
    logic                      w_stop2_nxt;
    logic                      r_par_bit;
    logic                      w_par_bit_nxt;
    logic                      r_is_break;
    logic                      w_is_break_nxt;
    logic                      r_serial;
    logic                      w_serial_nxt;
    logic                      r_active;
    logic                      r_done;
    logic                      w_done_nxt;

    // Frame-start helpers derived from the FIFO head and live config
    logic [3:0]                w_eff_bits;
    logic [MAX_DATA_WIDTH-1:0] w_mask;
    logic [MAX_DATA_WIDTH-1:0] w_head_masked;
    logic                      w_head_par;
    logic                      w_start_ok;
    logic                      w_bit_end;

    // Full is taken from the registered flag, so a write arriving while
    // full is dropped even if a pop happens in the same cycle.
    assign w_wr_acc   = wr_en && !r_full;
    assign w_start_ok = tx_enable && !cts_n && !r_empty && !send_break;
    assign w_bit_end  = baud_tick && (r_tick == c_TICK_LAST);
    assign w_tick_run = w_bit_end ? '0 : (baud_tick ? (r_tick + c_TW'(1)) : r_tick);

    always_comb begin
        w_eff_bits = cfg_data_bits;
        if (cfg_data_bits < c_MINW) begin
            w_eff_bits = c_MINW;
        end else if (cfg_data_bits > c_MAXW) begin
            w_eff_bits = c_MAXW;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            w_mask[i] = (4'(i) < w_eff_bits);
        end
    end

    assign w_head_masked = r_mem[r_rd_ptr] & w_mask;
    assign w_head_par    = (^w_head_masked) ^ cfg_parity_odd;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge uart_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_nxt = r_count + c_LW'(1);
            2'b01:   w_count_nxt = r_count - c_LW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_DEPTH);
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: state register
    // ------------------------------------------------------------------
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_nbits    <= c_MINW;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
            r_is_break <= 1'b0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_nbits    <= w_nbits_nxt;
            r_par_en   <= w_par_en_nxt;
            r_stop2    <= w_stop2_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_is_break <= w_is_break_nxt;
            r_serial   <= w_serial_nxt;
            r_active   <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = r_tick;
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_nbits_nxt    = r_nbits;
        w_par_en_nxt   = r_par_en;
        w_stop2_nxt    = r_stop2;
        w_par_bit_nxt  = r_par_bit;
        w_is_break_nxt = r_is_break;
        w_pop          = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tick_nxt = '0;
                if (send_break) begin
                    w_state_nxt = ST_BREAK;
                end else if (w_start_ok) begin
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                w_tick_nxt = w_tick_run;
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = '0;
                end
            end

            ST_DATA: begin
                w_tick_nxt = w_tick_run;
                if (w_bit_end) begin
                    if (r_bit == (r_nbits - 4'd1)) begin
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end

            ST_PARITY: begin
                w_tick_nxt = w_tick_run;
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_bit_nxt   = '0;
                end
            end

            ST_STOP: begin
                w_tick_nxt = w_tick_run;
                if (w_bit_end) begin
                    if (r_stop2 && (r_bit == 4'd0)) begin
                        w_bit_nxt = 4'd1;
                    end else begin
                        // Last stop tick: finish the frame and, if another
                        // word may go, start it with no idle gap.
                        w_done_nxt  = !r_is_break;
                        w_state_nxt = w_start_ok ? ST_START : ST_IDLE;
                    end
                end
            end

            ST_BREAK: begin
                w_tick_nxt = '0;
                if (!send_break) begin
                    // One bit period of mark after the break, no tx_done.
                    w_state_nxt    = ST_STOP;
                    w_bit_nxt      = '0;
                    w_stop2_nxt    = 1'b0;
                    w_is_break_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_tick_nxt  = '0;
            end
        endcase

        // Any transition into START pops the head and latches the frame
        // format, so config edits only take effect on the following frame.
        if ((w_state_nxt == ST_START) && (r_state != ST_START)) begin
            w_pop          = 1'b1;
            w_tick_nxt     = '0;
            w_bit_nxt      = '0;
            w_shift_nxt    = w_head_masked;
            w_nbits_nxt    = w_eff_bits;
            w_par_en_nxt   = cfg_parity_en;
            w_stop2_nxt    = cfg_stop2;
            w_par_bit_nxt  = w_head_par;
            w_is_break_nxt = 1'b0;
        end
    end

    // Line level is derived from the next state so it is registered
    // together with the state change.
    always_comb begin
        w_serial_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_serial_nxt = 1'b0;
            ST_DATA:   w_serial_nxt = w_shift_nxt[0];
            ST_PARITY: w_serial_nxt = w_par_bit_nxt;
            ST_BREAK:  w_serial_nxt = 1'b0;
            default:   w_serial_nxt = 1'b1;
        endcase
    end

    assign tx_serial   = r_serial;
    assign tx_empty    = r_empty;
    assign tx_full     = r_full;
    assign tx_level    = r_count;
    assign tx_active   = r_active;
    assign tx_done     = r_done;
    assign tx_overflow = r_overflow;

endmodule
`default_nettype wire
